// File: rtl/fft_twiddle_seq_gen.sv
// Radix-2 FFT twiddle sequencer: streams W_N^k for one butterfly stage
// from a quarter-wave cosine table, with conjugate mode and backpressure.
module fft_twiddle_seq_gen #(
  parameter int N      = 32,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  localparam int LOG2N = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LOG2N-1:0]  stage,
  input  logic              inverse,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-2:0]  out_k,
  output logic              out_last
);

  localparam int Q  = N / 4;
  localparam int RW = LOG2N - 2;
  localparam int KW = LOG2N - 1;
  localparam int TW = FRAC_W + 2;
  localparam longint PI_Q30 = 64'sd3373259426;
  localparam logic [LOG2N-1:0] SMAX = LOG2N'(LOG2N - 1);

  // Cosine table C[m] = round(2^FRAC_W*cos(2*pi*m/N)) built at elaboration
  // by a Q30 Taylor series, so no memory image file is needed.
  function automatic logic [(Q+1)*TW-1:0] cos_table();
    logic [(Q+1)*TW-1:0] t;
    longint x, x2, term, p, acc;
    t = '0;
    for (int m = 0; m <= Q; m++) begin
      x    = (PI_Q30 * 2 * longint'(m)) / longint'(N);
      x2   = (x * x) >>> 30;
      term = longint'(1) <<< 30;
      acc  = term;
      for (int n = 1; n <= 12; n++) begin
        p    = (term * x2) >>> 30;
        term = -p / longint'((2 * n - 1) * (2 * n));
        acc  = acc + term;
      end
      acc = (acc + (longint'(1) <<< (29 - FRAC_W))) >>> (30 - FRAC_W);
      if (acc < 0) acc = 0;
      t[m*TW +: TW] = TW'(acc);
    end
    return t;
  endfunction

  localparam logic [(Q+1)*TW-1:0] COS_T = cos_table();

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nx;

  logic [LOG2N-1:0]  s_q;
  logic              inv_q;
  logic [KW-1:0]     j_q;
  logic              en, issue, last_d;
  logic [KW:0]       span;
  logic [KW-1:0]     k_d;
  logic              v0, l0;
  logic [KW-1:0]     k0;
  logic [RW-1:0]     r0;
  logic [RW:0]       rb0;
  logic              v1, l1, q1;
  logic [KW-1:0]     k1;
  logic [TW-1:0]     ca1, cb1;
  logic [DATA_W-1:0] pa, pb, re_d, im_m, im_d;

  assign en     = ~out_valid | out_ready;
  assign issue  = (state == RUN) & en;
  assign span   = (KW+1)'(1) << s_q;
  assign last_d = ({1'b0, j_q} == span - 1'b1);
  assign k_d    = j_q << (KW - int'(s_q));
  assign r0     = k0[RW-1:0];
  assign rb0    = (RW+1)'(Q) - {1'b0, r0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (issue && last_d) state_nx = DRAIN;
      DRAIN:   if (out_valid && out_ready && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Second quadrant reuses the first: cos(pi/2+x) = -sin x, sin(pi/2+x) = cos x.
  always_comb begin
    pa   = DATA_W'(ca1);
    pb   = DATA_W'(cb1);
    re_d = q1 ? -pb : pa;
    im_m = q1 ? -pa : -pb;
    im_d = inv_q ? -im_m : im_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      inv_q     <= 1'b0;
      j_q       <= '0;
      v0        <= 1'b0;
      k0        <= '0;
      l0        <= 1'b0;
      v1        <= 1'b0;
      k1        <= '0;
      l1        <= 1'b0;
      q1        <= 1'b0;
      ca1       <= '0;
      cb1       <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_k     <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        s_q   <= (stage > SMAX) ? SMAX : stage;
        inv_q <= inverse;
        j_q   <= '0;
      end else if (issue) begin
        j_q <= j_q + 1'b1;
      end
      if (en) begin
        v0        <= issue;
        k0        <= k_d;
        l0        <= last_d;
        v1        <= v0;
        k1        <= k0;
        l1        <= l0;
        q1        <= k0[KW-1];
        ca1       <= COS_T[r0*TW +: TW];
        cb1       <= COS_T[rb0*TW +: TW];
        out_valid <= v1;
        if (v1) begin
          out_re   <= re_d;
          out_im   <= im_d;
          out_k    <= k1;
          out_last <= l1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_twiddle_seq_gen.sv
// Scoreboard bench for fft_twiddle_seq_gen: real-valued twiddle model,
// random stages/modes/backpressure, spurious starts and mid-sequence reset.
module tb_fft_twiddle_seq_gen;

  localparam int N      = 8;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int LOG2N  = 3;
  localparam int KW     = LOG2N - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LOG2N-1:0]  stage;
  logic              inverse;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic [KW-1:0]     out_k;
  logic              out_last;

  fft_twiddle_seq_gen #(.N(N), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stage     (stage),
    .inverse   (inverse),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_k     (out_k),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KW-1:0]     k;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    checks     = 0;
  int    failures   = 0;
  int    beats_seen = 0;
  bit    ready_rand = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rnd(real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // W_N^k = cos(2pi k/N) - j sin(2pi k/N), scaled and rounded.
  function automatic int seq_len(int s);
    int sc;
    sc = (s > LOG2N - 1) ? LOG2N - 1 : s;
    return 1 << sc;
  endfunction

  function automatic void push_seq(int s, bit inv);
    int    cnt;
    int    k;
    int    im;
    real   a;
    real   sc;
    beat_t b;
    cnt = seq_len(s);
    sc  = real'(1 << FRAC_W);
    for (int j = 0; j < cnt; j++) begin
      k = j * (N / 2) / cnt;
      a = 2.0 * 3.14159265358979 * real'(k) / real'(N);
      im = -rnd(sc * $sin(a));
      if (inv) im = -im;
      b.k    = KW'(k);
      b.re   = DATA_W'(rnd(sc * $cos(a)));
      b.im   = DATA_W'(im);
      b.last = (j == cnt - 1);
      exp_q.push_back(b);
    end
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall hold.
  initial begin
    beat_t held_b;
    beat_t e;
    bit    held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      if (held)
        check("stall_hold", 64'({out_valid, out_k, out_re, out_im, out_last}),
              64'({1'b1, held_b}));
      held   = out_valid & ~out_ready;
      held_b = {out_k, out_re, out_im, out_last};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({out_k, out_re, out_im, out_last}), 64'(e));
          beats_seen++;
        end
      end
    end
  end

  task automatic run_seq(int s, bit inv, bit spurious);
    int c;
    @(posedge clk);
    #1;
    check("idle_before_start", 64'(busy), 64'(0));
    start   = 1'b1;
    stage   = LOG2N'(s);
    inverse = inv;
    push_seq(s, inv);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("valid_lat_t0", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("valid_lat_t1", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("valid_lat_t2", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("valid_lat_t3", 64'(out_valid), 64'(1));
    c = 0;
    while (busy && c < 400) begin
      if (spurious && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        stage = LOG2N'($urandom_range(0, 7));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      c++;
    end
    check("busy_drops", 64'(busy), 64'(0));
    if (!ready_rand)
      check("throughput_cycles", 64'(c), 64'(seq_len(s)));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("valid_after_done", 64'(out_valid), 64'(0));
  endtask

  task automatic reset_mid_seq();
    int  base;
    int  c;
    bit  any_valid;
    ready_rand = 1'b0;
    base = beats_seen;
    @(posedge clk);
    #1;
    start   = 1'b1;
    stage   = LOG2N'(2);
    inverse = 1'($urandom_range(0, 1));
    push_seq(2, inverse);
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 0;
    while (beats_seen < base + 2 && c < 50) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("two_beats_before_reset", 64'(beats_seen - base), 64'(2));
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'(0));
    check("rst_async_busy", 64'(busy), 64'(0));
    check("rst_async_data", 64'({out_re, out_im, out_k, out_last}), 64'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      any_valid |= out_valid | busy;
    end
    check("no_beat_after_reset", 64'(any_valid), 64'(0));
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    stage   = '0;
    inverse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({busy, out_valid, out_last}), 64'(0));
    check("reset_data", 64'({out_re, out_im, out_k}), 64'(0));
    #1;
    rst_n = 1'b1;

    run_seq(2, 1'b0, 1'b0);
    run_seq(2, 1'b1, 1'b0);
    run_seq(0, 1'b0, 1'b0);
    run_seq(7, 1'b0, 1'b0);
    run_seq(1, 1'b1, 1'b0);
    ready_rand = 1'b1;
    run_seq(2, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++)
      run_seq($urandom_range(0, 7), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    reset_mid_seq();
    ready_rand = 1'b1;
    run_seq(2, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
